// File: rtl/er_cfg_ctrl.sv
// Configuration and sequencing controller for the executable-region immutability monitor.
// Holds the ER bounds, locks them while armed/running, and tracks legal entry/exit of the region.
module er_cfg_ctrl #(
    parameter logic [15:0] CFG_BASE   = 16'h0190,
    parameter logic [15:0] ER_MIN_RST = 16'hE000,
    parameter logic [15:0] ER_MAX_RST = 16'hE0FE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_wdata,
    output logic [15:0] data_rdata,
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic        cfg_locked,
    output logic        er_running,
    output logic        er_done,
    output logic        er_abort,
    output logic        cfg_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARMED   = 3'd1;
    localparam logic [2:0] RUNNING = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] ABORT   = 3'd4;

    localparam logic [15:0] ADDR_MIN  = CFG_BASE;
    localparam logic [15:0] ADDR_MAX  = CFG_BASE + 16'd2;
    localparam logic [15:0] ADDR_CTRL = CFG_BASE + 16'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] prev_pc;
    logic        cpu_wr;
    logic        wr_min;
    logic        wr_max;
    logic        wr_ctrl;
    logic        dma_hit;
    logic        locked_now;
    logic        cfg_valid;
    logic        pc_in;
    logic        arm_bad;
    logic        err_set;
    logic        bit_arm;
    logic        bit_clr;
    logic        bit_errclr;

    assign cpu_wr     = data_en & data_wr;
    assign wr_min     = cpu_wr && (data_addr == ADDR_MIN);
    assign wr_max     = cpu_wr && (data_addr == ADDR_MAX);
    assign wr_ctrl    = cpu_wr && (data_addr == ADDR_CTRL);
    assign dma_hit    = dma_en && ((dma_addr == ADDR_MIN) || (dma_addr == ADDR_MAX) ||
                                   (dma_addr == ADDR_CTRL));
    assign bit_arm    = data_wdata[0];
    assign bit_clr    = data_wdata[1];
    assign bit_errclr = data_wdata[2];

    assign locked_now = (state == ARMED) || (state == RUNNING);
    assign cfg_valid  = (er_min <= er_max) && !er_min[0] && !er_max[0];
    assign pc_in      = (pc >= er_min) && (pc <= er_max);
    assign arm_bad    = wr_ctrl && bit_arm && (state == IDLE) && !cfg_valid;
    assign err_set    = dma_hit || ((wr_min || wr_max) && locked_now) || arm_bad;

    // Priorities: disarm beats entry in ARMED, CLR beats re-entry in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_ctrl && bit_arm && cfg_valid) state_nxt = ARMED;
            end
            ARMED: begin
                if (wr_ctrl && !bit_arm)                    state_nxt = IDLE;
                else if (pc == er_min)                      state_nxt = RUNNING;
                else if ((pc > er_min) && (pc <= er_max))   state_nxt = ABORT;
            end
            RUNNING: begin
                if (!pc_in) state_nxt = (prev_pc == er_max) ? DONE : ABORT;
            end
            DONE: begin
                if (wr_ctrl && bit_clr) state_nxt = IDLE;
                else if (pc == er_min)  state_nxt = RUNNING;
            end
            ABORT: begin
                if (wr_ctrl && bit_clr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_rdata = 16'h0000;
        if (data_addr == ADDR_MIN)       data_rdata = er_min;
        else if (data_addr == ADDR_MAX)  data_rdata = er_max;
        else if (data_addr == ADDR_CTRL) data_rdata = {12'b0, cfg_err, state};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            er_min     <= ER_MIN_RST;
            er_max     <= ER_MAX_RST;
            prev_pc    <= 16'h0000;
            cfg_err    <= 1'b0;
            cfg_locked <= 1'b0;
            er_running <= 1'b0;
            er_done    <= 1'b0;
            er_abort   <= 1'b0;
        end else begin
            state   <= state_nxt;
            prev_pc <= pc;
            if (wr_min && !locked_now) er_min <= data_wdata;
            if (wr_max && !locked_now) er_max <= data_wdata;
            if (err_set)                     cfg_err <= 1'b1;
            else if (wr_ctrl && bit_errclr)  cfg_err <= 1'b0;
            cfg_locked <= (state_nxt == ARMED) || (state_nxt == RUNNING);
            er_running <= (state_nxt == RUNNING);
            er_done    <= (state_nxt == DONE);
            er_abort   <= (state_nxt == ABORT);
        end
    end

endmodule

// File: tb/tb_er_cfg_ctrl.sv
// Self-checking bench for er_cfg_ctrl: directed scenarios then randomized traffic
// compared against a behavioural model of the ER sequencing rules.
module tb_er_cfg_ctrl;

    localparam logic [15:0] BASE = 16'h0190;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_wdata;
    logic [15:0] data_rdata;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic [15:0] er_min;
    logic [15:0] er_max;
    logic        cfg_locked;
    logic        er_running;
    logic        er_done;
    logic        er_abort;
    logic        cfg_err;

    int checks = 0;
    int passed = 0;

    // Model: mode is the spec's state number (0 idle,1 armed,2 running,3 done,4 abort).
    int          m_mode;
    logic [15:0] m_min;
    logic [15:0] m_max;
    logic [15:0] m_prev;
    logic        m_err;

    er_cfg_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc),
        .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .dma_addr(dma_addr), .dma_en(dma_en),
        .er_min(er_min), .er_max(er_max), .cfg_locked(cfg_locked),
        .er_running(er_running), .er_done(er_done), .er_abort(er_abort),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_min = 16'hE000; m_max = 16'hE0FE; m_prev = 16'h0000; m_err = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a == BASE)       return m_min;
        if (a == BASE + 2)   return m_max;
        if (a == BASE + 4)   return {12'b0, m_err, 3'(m_mode)};
        return 16'h0000;
    endfunction

    task automatic model_step();
        bit          w_min, w_max, w_ctl, dma_bad, locked, ok, err_new;
        int          nxt;
        logic [15:0] d;
        d       = data_wdata;
        w_min   = data_en && data_wr && data_addr == BASE;
        w_max   = data_en && data_wr && data_addr == BASE + 2;
        w_ctl   = data_en && data_wr && data_addr == BASE + 4;
        dma_bad = dma_en && (dma_addr == BASE || dma_addr == BASE + 2 || dma_addr == BASE + 4);
        locked  = (m_mode == 1 || m_mode == 2);
        ok      = (m_min <= m_max) && (m_min % 2 == 0) && (m_max % 2 == 0);
        err_new = dma_bad || (locked && (w_min || w_max));
        nxt     = m_mode;
        if (m_mode == 0) begin
            if (w_ctl && d[0]) begin
                if (ok) nxt = 1;
                else err_new = 1;
            end
        end else if (m_mode == 1) begin
            if (w_ctl && !d[0]) nxt = 0;
            else if (pc == m_min) nxt = 2;
            else if (pc > m_min && pc <= m_max) nxt = 4;
        end else if (m_mode == 2) begin
            if (pc < m_min || pc > m_max) nxt = (m_prev == m_max) ? 3 : 4;
        end else if (m_mode == 3) begin
            if (w_ctl && d[1]) nxt = 0;
            else if (pc == m_min) nxt = 2;
        end else begin
            if (w_ctl && d[1]) nxt = 0;
        end
        if (!locked && w_min) m_min = d;
        if (!locked && w_max) m_max = d;
        if (err_new) m_err = 1'b1;
        else if (w_ctl && d[2]) m_err = 1'b0;
        m_prev = pc;
        m_mode = nxt;
    endtask

    task automatic check_outputs();
        check("er_min", er_min, m_min);
        check("er_max", er_max, m_max);
        check("cfg_locked", 16'(cfg_locked), 16'(m_mode == 1 || m_mode == 2));
        check("er_running", 16'(er_running), 16'(m_mode == 2));
        check("er_done", 16'(er_done), 16'(m_mode == 3));
        check("er_abort", 16'(er_abort), 16'(m_mode == 4));
        check("cfg_err", 16'(cfg_err), 16'(m_err));
    endtask

    // One clock cycle: drive, check comb read, clock, advance model, check registered outputs.
    task automatic cycle(input logic [15:0] p, input logic [15:0] a, input logic en,
                         input logic wr, input logic [15:0] wd,
                         input logic [15:0] da, input logic den);
        pc = p; data_addr = a; data_en = en; data_wr = wr; data_wdata = wd;
        dma_addr = da; dma_en = den;
        #1;
        check("data_rdata", data_rdata, model_read(a));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic cpu_wr(input logic [15:0] p, input logic [15:0] a, input logic [15:0] d);
        cycle(p, a, 1'b1, 1'b1, d, 16'h0000, 1'b0);
    endtask

    task automatic run_pc(input logic [15:0] p);
        cycle(p, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_running", 16'(er_running), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] p, a, d;
        int r;
        reset = 1'b1; pc = 0; data_addr = 0; data_en = 0; data_wr = 0; data_wdata = 0;
        dma_addr = 0; dma_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        data_addr = BASE + 4;
        #1;
        check("rst_ctrl", data_rdata, 16'h0000);
        check("rst_min", er_min, 16'hE000);
        check("rst_max", er_max, 16'hE0FE);

        // Legal entry and exit
        cpu_wr(16'h0, BASE, 16'hE100);
        cpu_wr(16'h0, BASE + 2, 16'hE1FE);
        cpu_wr(16'h0, BASE + 4, 16'h0001);
        check("armed_lock", 16'(cfg_locked), 16'h1);
        run_pc(16'hE100);
        check("entry_run", 16'(er_running), 16'h1);
        run_pc(16'hE102);
        run_pc(16'hE1FE);
        run_pc(16'hC000);
        check("exit_done", 16'(er_done), 16'h1);
        cpu_wr(16'hC000, BASE + 4, 16'h0002);
        check("done_clr", 16'(er_done), 16'h0);

        // Illegal entry mid-region
        cpu_wr(16'h0, BASE + 4, 16'h0001);
        run_pc(16'hE104);
        check("mid_entry_abort", 16'(er_abort), 16'h1);
        cpu_wr(16'h0, BASE + 4, 16'h0002);
        check("abort_clr", 16'(er_abort), 16'h0);
        check("abort_clr_err", 16'(cfg_err), 16'h0);

        // Locked write, DMA hit, ERRCLR while running
        cpu_wr(16'h0, BASE + 4, 16'h0001);
        run_pc(16'hE100);
        cpu_wr(16'hE102, BASE + 2, 16'hFFFE);
        check("locked_max", er_max, 16'hE1FE);
        check("locked_err", 16'(cfg_err), 16'h1);
        cpu_wr(16'hE104, BASE + 4, 16'h0004);
        check("errclr", 16'(cfg_err), 16'h0);
        check("errclr_run", 16'(er_running), 16'h1);
        cycle(16'hE106, 16'h0, 1'b0, 1'b0, 16'h0, BASE, 1'b1);
        check("dma_err", 16'(cfg_err), 16'h1);
        check("dma_run", 16'(er_running), 16'h1);
        do_reset();
        check("rst_mid_min", er_min, 16'hE000);

        // Invalid arm
        cpu_wr(16'h0, BASE, 16'hE200);
        cpu_wr(16'h0, BASE + 2, 16'hE100);
        cpu_wr(16'h0, BASE + 4, 16'h0001);
        check("bad_arm_lock", 16'(cfg_locked), 16'h0);
        check("bad_arm_err", 16'(cfg_err), 16'h1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 699) do_reset();
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    p = m_min;
                2:       p = m_max;
                3:       p = m_min + 16'd2;
                4, 5:    p = m_min + 16'(2 * $urandom_range(0, 12));
                6, 7:    p = 16'h0100;
                8:       p = 16'($urandom);
                default: p = m_prev;
            endcase
            r = $urandom_range(0, 99);
            d = (r % 5 == 0) ? 16'($urandom) : 16'hE000 + 16'(2 * $urandom_range(0, 160));
            if ($urandom_range(0, 30) == 0) d = 16'hFFFE;
            if (r < 8)       cpu_wr(p, BASE, d);
            else if (r < 16) cpu_wr(p, BASE + 2, d);
            else if (r < 30) cpu_wr(p, BASE + 4, 16'($urandom_range(0, 7)));
            else if (r < 34) cycle(p, 16'h0, 1'b0, 1'b0, 16'h0,
                                   BASE + 16'(2 * $urandom_range(0, 2)), 1'b1);
            else if (r < 40) begin
                a = BASE + 16'(2 * $urandom_range(0, 3));
                cycle(p, a, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
            end else run_pc(p);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
